// File: rtl/mult_share_pkg.sv
// Shared constants and datapath types for the shared-multiplier scheduler.
package mult_share_pkg;

    localparam int MULT_W       = 8;
    localparam int PROD_W       = 16;
    localparam int DEFAULT_NREQ = 4;

    typedef logic [MULT_W-1:0] operand_t;
    typedef logic [PROD_W-1:0] product_t;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Requester/response channel bundle between client logic and the scheduler.
interface mult_share_ctrl_if
    import mult_share_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int ID_W = $clog2(NREQ)
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*MULT_W-1:0] req_a;
    logic [NREQ*MULT_W-1:0] req_b;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    product_t               rsp_p;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_ready;
    logic                   busy;

    // Client side: issues operands, consumes products.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p, rsp_id, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p, rsp_id, busy
    );

endinterface

// File: rtl/exact_multi.sv
// Combinational 8x8 unsigned exact multiplier with a full 16-bit product.
module exact_multi
    import mult_share_pkg::*;
(
    input  operand_t A,
    input  operand_t B,
    output product_t P
);

    // Operands are widened to the product width before multiplying, so no bits are lost.
    assign P = product_t'(A) * product_t'(B);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (with wrap) wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    // Search upward from ptr; grant is one-hot when enabled and something is requesting.
    always_comb begin
        int   c;
        logic found;
        // NOTE: every output and local gets a default first so no latch is inferred.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (!found && req[IDX_W'(c)]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
        if (found && en) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one exact multiplier between NREQ requesters through a 2-stage pipeline.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    mult_share_ctrl_if.slave  bus
);

    operand_t        a_arr [NREQ];
    operand_t        b_arr [NREQ];

    logic            v1, v2;
    operand_t        a1, b1;
    logic [ID_W-1:0] id1, id2;
    product_t        p2;
    product_t        prod;
    logic [ID_W-1:0] ptr;

    logic            adv1, adv2, en, accept;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] g;

    // Unpack the flat operand buses into per-requester lanes.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[i*MULT_W +: MULT_W];
        assign b_arr[i] = bus.req_b[i*MULT_W +: MULT_W];
    end

    // S2 drains when empty or popped; S1 drains when empty or S2 advances.
    assign adv2   = !v2 || bus.rsp_ready;
    assign adv1   = !v1 || adv2;
    assign en     = adv1 && !rst;
    assign accept = |grant;

    rr_arbiter #(.N(NREQ), .IDX_W(ID_W)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .en    (en),
        .grant (grant),
        .idx   (g)
    );

    exact_multi u_mult (
        .A (a1),
        .B (b1),
        .P (prod)
    );

    // Pipeline registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are cleared along with the valids so outputs read 0 out of reset.
            v1  <= 1'b0;
            v2  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            id1 <= '0;
            p2  <= '0;
            id2 <= '0;
            ptr <= '0;
        end else begin
            // NOTE: non-blocking assignments let S2 capture the old S1 while S1 loads new operands.
            if (adv2) begin
                v2  <= v1;
                p2  <= prod;
                id2 <= id1;
            end
            if (accept) begin
                v1  <= 1'b1;
                a1  <= a_arr[g];
                b1  <= b_arr[g];
                id1 <= g;
                ptr <= (g == ID_W'(NREQ - 1)) ? '0 : g + ID_W'(1);
            end else if (adv1) begin
                v1  <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = v2;
    assign bus.rsp_p     = p2;
    assign bus.rsp_id    = id2;
    assign bus.busy      = v1 || v2;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with hand-computed expected values.
module tb_mult_share_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    mult_share_ctrl_if #(.NREQ(4)) bus ();

    mult_share_ctrl #(.NREQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        bus.req_a[i*8 +: 8] = 8'(a);
        bus.req_b[i*8 +: 8] = 8'(b);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, i + 1, 10);

        // Reset held 3 cycles with all requests valid.
        repeat (3) begin
            tick();
            check("rst_ready", 32'(bus.req_ready), 0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            check("rst_busy", 32'(bus.busy), 0);
        end
        check("rst_rsp_p", 32'(bus.rsp_p), 0);
        check("rst_rsp_id", 32'(bus.rsp_id), 0);
        rst = 1'b0;
        #1;
        check("first_grant", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = 4'h0;
        tick();
        check("idle_busy", 32'(bus.busy), 0);

        // Single request: req 2, 3*5.
        set_op(2, 3, 5);
        bus.req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        bus.req_valid = 4'h0;
        check("single_busy_t1", 32'(bus.busy), 1);
        check("single_valid_t1", 32'(bus.rsp_valid), 0);
        tick();
        check("single_valid_t2", 32'(bus.rsp_valid), 1);
        check("single_p", 32'(bus.rsp_p), 15);
        check("single_id", 32'(bus.rsp_id), 2);
        tick();
        check("single_valid_pop", 32'(bus.rsp_valid), 0);
        check("single_busy_pop", 32'(bus.busy), 0);

        // Reset pulse brings the pointer back to 0, then full contention.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, i + 1, 10);
        bus.req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_grant", 32'(bus.req_ready), 32'(1) << (k % 4));
            tick();
            if (k == 0) begin
                check("rr_valid_first", 32'(bus.rsp_valid), 0);
            end else begin
                check("rr_valid", 32'(bus.rsp_valid), 1);
                check("rr_id", 32'(bus.rsp_id), 32'((k - 1) % 4));
                check("rr_p", 32'(bus.rsp_p), 32'(10 * ((k - 1) % 4 + 1)));
            end
        end
        bus.req_valid = 4'h0;
        tick();
        check("rr_tail_id", 32'(bus.rsp_id), 1);
        check("rr_tail_p", 32'(bus.rsp_p), 20);
        tick();
        check("rr_drain_valid", 32'(bus.rsp_valid), 0);
        check("rr_drain_busy", 32'(bus.busy), 0);

        // Back-pressure: 255*255 from req 1, then 0*7 from req 3; req 0 blocked behind them.
        bus.rsp_ready = 1'b0;
        set_op(1, 255, 255);
        bus.req_valid = 4'b0010;
        #1;
        check("bp_ready_a", 32'(bus.req_ready), 32'b0010);
        tick();
        set_op(3, 0, 7);
        bus.req_valid = 4'b1000;
        #1;
        check("bp_ready_b", 32'(bus.req_ready), 32'b1000);
        tick();
        set_op(0, 9, 9);
        bus.req_valid = 4'b0001;
        #1;
        check("bp_full_ready", 32'(bus.req_ready), 0);
        check("bp_full_busy", 32'(bus.busy), 1);
        repeat (3) begin
            tick();
            check("bp_hold_ready", 32'(bus.req_ready), 0);
            check("bp_hold_valid", 32'(bus.rsp_valid), 1);
            check("bp_hold_p", 32'(bus.rsp_p), 65025);
            check("bp_hold_id", 32'(bus.rsp_id), 1);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid = 4'h0;
        check("bp_second_valid", 32'(bus.rsp_valid), 1);
        check("bp_second_id", 32'(bus.rsp_id), 3);
        check("bp_second_p", 32'(bus.rsp_p), 0);
        tick();
        check("bp_third_id", 32'(bus.rsp_id), 0);
        check("bp_third_p", 32'(bus.rsp_p), 81);
        tick();
        check("bp_drain_valid", 32'(bus.rsp_valid), 0);
        check("bp_drain_busy", 32'(bus.busy), 0);

        // Reset mid-operation: two accepts held by back-pressure, then discarded.
        bus.rsp_ready = 1'b0;
        set_op(0, 2, 2);
        set_op(2, 4, 4);
        bus.req_valid = 4'b0101;
        #1;
        check("mid_grant_a", 32'(bus.req_ready), 32'b0100);
        tick();
        check("mid_grant_b", 32'(bus.req_ready), 32'b0001);
        tick();
        check("mid_busy_before", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        check("mid_busy_after", 32'(bus.busy), 0);
        check("mid_valid_after", 32'(bus.rsp_valid), 0);
        check("mid_ptr_restart", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = 4'h0;
        bus.rsp_ready = 1'b1;
        repeat (3) begin
            tick();
            check("mid_no_rsp", 32'(bus.rsp_valid), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
